// File: rtl/cpu_defs.sv
// ============================================================================
// Module   : cpu_defs (package)
// Brief    : EX/MEM and MEM/WB bundle layout, MEM-stage FSM encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam int EXMEM_W     = 141;
    localparam int MEMWB_W     = 104;

    localparam int EX_TGT_LSB  = 0;
    localparam int EX_RD_LSB   = 32;
    localparam int EX_SD_LSB   = 37;
    localparam int EX_ALU_LSB  = 69;
    localparam int ZERO        = 101;
    localparam int MEMREAD     = 102;
    localparam int MEMWRITE    = 103;
    localparam int BRANCH      = 104;
    localparam int REGWRITE    = 105;
    localparam int MEMTOREG    = 106;
    localparam int JUMP        = 107;
    localparam int VALID       = 108;
    localparam int EX_INSN_LSB = 109;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dm_state_e;

    // Only the fields needed to finish an access and write it back.
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memtoreg;
        logic        store;
    } hold_t;

    function automatic logic [MEMWB_W-1:0] pack_memwb(
        input logic [31:0] ld_data,
        input logic [31:0] alu,
        input logic [4:0]  rd,
        input logic        regwrite,
        input logic        memtoreg,
        input logic        valid,
        input logic [31:0] insn
    );
        pack_memwb = {insn, valid, memtoreg, regwrite, rd, alu, ld_data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
// Module   : mem_stage_if
// Brief    : Pipeline bundles, control strobes and data-memory bus of the MEM stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
    import cpu_defs::*;

    logic [EXMEM_W-1:0] exmem;
    logic [MEMWB_W-1:0] memwb;
    logic               stall;
    logic               pc_src;
    logic [31:0]        branch_target;
    logic               dm_req;
    logic               dm_we;
    logic [31:0]        dm_addr;
    logic [31:0]        dm_wdata;
    logic [31:0]        dm_rdata;
    logic               dm_ack;
    logic               mem_err;

    modport master (
        input  exmem, dm_rdata, dm_ack,
        output memwb, stall, pc_src, branch_target,
               dm_req, dm_we, dm_addr, dm_wdata, mem_err
    );

    modport slave (
        output exmem, dm_rdata, dm_ack,
        input  memwb, stall, pc_src, branch_target,
               dm_req, dm_we, dm_addr, dm_wdata, mem_err
    );
endinterface

`default_nettype wire

// File: rtl/dm_handshake.sv
// ============================================================================
// Module   : dm_handshake
// Brief    : IDLE/BUSY request FSM with ack timeout for the data-memory bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_handshake
    import cpu_defs::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic start,
    input  wire logic start_we,
    input  wire logic ack,
    output logic      req,
    output logic      we,
    output logic      busy,
    output logic      done,
    output logic      timeout
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    dm_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          w_at_limit;

    always_comb begin
        w_at_limit = (cnt_q == C_LAST);
        busy       = (state_q == ST_BUSY);
        // An ack arriving on the last permitted cycle completes normally.
        done       = busy && (ack || w_at_limit);
        timeout    = busy && !ack && w_at_limit;

        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = ST_BUSY;
                    req_d   = 1'b1;
                    we_d    = start_we;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
        end
    end

    assign req = req_q;
    assign we  = we_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline MEM stage: loads/stores over req/ack, branch redirect, MEM/WB register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import cpu_defs::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  wire logic  CLK,
    input  wire logic  RST_N,
    mem_stage_if.master bus
);

    hold_t              hold_q, hold_d;
    logic [MEMWB_W-1:0] memwb_q, memwb_d;
    logic               pc_src_q, pc_src_d;
    logic [31:0]        tgt_q, tgt_d;
    logic               mem_err_q, mem_err_d;

    logic               w_busy, w_done, w_timeout, w_req, w_we;
    logic               w_start, w_start_we;
    logic [EXMEM_W-1:0] w_ex;
    logic [31:0]        w_alu;
    logic               w_valid, w_memop, w_misal, w_redirect;

    dm_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
        .clk      (CLK),
        .rst_n    (RST_N),
        .start    (w_start),
        .start_we (w_start_we),
        .ack      (bus.dm_ack),
        .req      (w_req),
        .we       (w_we),
        .busy     (w_busy),
        .done     (w_done),
        .timeout  (w_timeout)
    );

    always_comb begin
        w_ex       = bus.exmem;
        w_alu      = w_ex[EX_ALU_LSB +: 32];
        w_valid    = w_ex[VALID] && !w_busy;
        w_memop    = w_ex[MEMREAD] || w_ex[MEMWRITE];
        w_misal    = (w_alu[1:0] != 2'b00);
        w_start    = w_valid && w_memop && !w_misal;
        w_start_we = w_ex[MEMWRITE];
        w_redirect = w_valid && ((w_ex[BRANCH] && w_ex[ZERO]) || w_ex[JUMP]);

        hold_d    = hold_q;
        memwb_d   = '0;
        mem_err_d = mem_err_q;
        pc_src_d  = w_redirect;
        tgt_d     = w_redirect ? w_ex[EX_TGT_LSB +: 32] : 32'h0;

        if (w_busy) begin
            if (w_done) begin
                memwb_d = pack_memwb(
                    w_timeout ? ERR_DATA : (hold_q.store ? 32'h0 : bus.dm_rdata),
                    hold_q.alu, hold_q.rd,
                    hold_q.regwrite && !hold_q.store && !w_timeout,
                    hold_q.memtoreg, 1'b1, hold_q.insn);
            end
            if (w_timeout) begin
                mem_err_d = 1'b1;
            end
        end else if (w_valid) begin
            if (!w_memop || w_misal) begin
                // A misaligned access retires without touching memory or the register file.
                memwb_d = pack_memwb(32'h0, w_alu, w_ex[EX_RD_LSB +: 5],
                                     w_ex[REGWRITE] && !w_memop, w_ex[MEMTOREG],
                                     1'b1, w_ex[EX_INSN_LSB +: 32]);
                if (w_memop) begin
                    mem_err_d = 1'b1;
                end
            end else begin
                hold_d.insn     = w_ex[EX_INSN_LSB +: 32];
                hold_d.alu      = w_alu;
                hold_d.sdata    = w_ex[EX_SD_LSB +: 32];
                hold_d.rd       = w_ex[EX_RD_LSB +: 5];
                hold_d.regwrite = w_ex[REGWRITE];
                hold_d.memtoreg = w_ex[MEMTOREG];
                hold_d.store    = w_ex[MEMWRITE];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold_q    <= '0;
            memwb_q   <= '0;
            pc_src_q  <= 1'b0;
            tgt_q     <= 32'h0;
            mem_err_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            memwb_q   <= memwb_d;
            pc_src_q  <= pc_src_d;
            tgt_q     <= tgt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign bus.memwb         = memwb_q;
    assign bus.stall         = w_busy;
    assign bus.pc_src        = pc_src_q;
    assign bus.branch_target = tgt_q;
    assign bus.dm_req        = w_req;
    assign bus.dm_we         = w_we;
    assign bus.dm_addr       = w_req ? hold_q.alu   : 32'h0;
    assign bus.dm_wdata      = w_req ? hold_q.sdata : 32'h0;
    assign bus.mem_err       = mem_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed vector table plus multi-cycle sequences for mem_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam logic [7:0] C_V = 8'h80, C_J = 8'h40, C_MTR = 8'h20, C_RW = 8'h10;
    localparam logic [7:0] C_BR = 8'h08, C_MW = 8'h04, C_MR = 8'h02, C_Z = 8'h01;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [140:0] exm;
        logic [103:0] wb;
        logic         pc;
        logic [31:0]  tgt;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [140:0] ex(input logic [31:0] insn, input logic [31:0] alu,
                                        input logic [31:0] sd, input logic [31:0] tgt,
                                        input logic [4:0] rd, input logic [7:0] ctl);
        ex = {insn, ctl, alu, sd, rd, tgt};
    endfunction

    function automatic logic [103:0] wb(input logic [31:0] ld, input logic [31:0] alu,
                                        input logic [4:0] rd, input logic rw, input logic mtr,
                                        input logic v, input logic [31:0] insn);
        wb = {insn, v, mtr, rw, rd, alu, ld};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        tbl[0] = '{141'h0, 104'h0, 1'b0, 32'h0};
        tbl[1] = '{ex(32'h00C28293, 32'h10, 32'h0, 32'h0, 5'd5, C_V | C_RW),
                   wb(32'h0, 32'h10, 5'd5, 1'b1, 1'b0, 1'b1, 32'h00C28293), 1'b0, 32'h0};
        tbl[2] = '{ex(32'h40B50533, 32'hFFFFFFFF, 32'hAAAA5555, 32'h1234, 5'd31, C_V | C_MTR),
                   wb(32'h0, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, 1'b1, 32'h40B50533), 1'b0, 32'h0};
        tbl[3] = '{ex(32'h00628463, 32'h0, 32'h0, 32'h00400020, 5'd0, C_V | C_BR | C_Z),
                   wb(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h00628463), 1'b1, 32'h00400020};
        tbl[4] = '{ex(32'h0, 32'h0, 32'h0, 32'h00400020, 5'd0, C_BR | C_Z | C_J),
                   104'h0, 1'b0, 32'h0};
        tbl[5] = '{ex(32'h00628463, 32'h5, 32'h0, 32'h00400020, 5'd0, C_V | C_BR),
                   wb(32'h0, 32'h5, 5'd0, 1'b0, 1'b0, 1'b1, 32'h00628463), 1'b0, 32'h0};
        tbl[6] = '{ex(32'h0000106F, 32'h404, 32'h0, 32'h00001000, 5'd1, C_V | C_J | C_RW),
                   wb(32'h0, 32'h404, 5'd1, 1'b1, 1'b0, 1'b1, 32'h0000106F), 1'b1, 32'h00001000};
        tbl[7] = '{141'h0, 104'h0, 1'b0, 32'h0};

        rst_n = 1'b0;
        bus.exmem = '0;
        bus.dm_ack = 1'b0;
        bus.dm_rdata = 32'h0;
        step();
        step();
        chk("rst_memwb", bus.memwb, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_pc_src", bus.pc_src, 0);
        chk("rst_dm_req", bus.dm_req, 0);
        chk("rst_mem_err", bus.mem_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.exmem = tbl[i].exm;
            step();
            chk($sformatf("vec%0d_memwb", i), bus.memwb, tbl[i].wb);
            chk($sformatf("vec%0d_pc_src", i), bus.pc_src, tbl[i].pc);
            if (tbl[i].pc) chk($sformatf("vec%0d_target", i), bus.branch_target, tbl[i].tgt);
            chk($sformatf("vec%0d_stall", i), bus.stall, 0);
        end

        // Load at 0x100, ack in the fourth busy cycle.
        bus.exmem = ex(32'h10002383, 32'h100, 32'h0, 32'h0, 5'd7, C_V | C_RW | C_MTR | C_MR);
        step();
        chk("ld_memwb_accept", bus.memwb, 0);
        chk("ld_addr", bus.dm_addr, 32'h100);
        chk("ld_we", bus.dm_we, 0);
        chk("ld_stall0", bus.stall, 1);
        bus.exmem = '0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("ld_stall%0d", i), bus.stall, 1);
            chk($sformatf("ld_req%0d", i), bus.dm_req, 1);
        end
        bus.dm_ack = 1'b1;
        bus.dm_rdata = 32'hCAFEF00D;
        step();
        bus.dm_ack = 1'b0;
        chk("ld_memwb", bus.memwb, wb(32'hCAFEF00D, 32'h100, 5'd7, 1'b1, 1'b1, 1'b1, 32'h10002383));
        chk("ld_stall_end", bus.stall, 0);
        chk("ld_req_end", bus.dm_req, 0);

        // Store at 0x104 with an ALU op held behind it.
        bus.exmem = ex(32'h0062A223, 32'h104, 32'h12345678, 32'h0, 5'd3, C_V | C_RW | C_MW);
        step();
        chk("st_we", bus.dm_we, 1);
        chk("st_wdata", bus.dm_wdata, 32'h12345678);
        chk("st_addr", bus.dm_addr, 32'h104);
        bus.exmem = ex(32'h05500493, 32'h55, 32'h0, 32'h0, 5'd9, C_V | C_RW);
        step();
        chk("st_stall", bus.stall, 1);
        bus.dm_ack = 1'b1;
        bus.dm_rdata = 32'h11111111;
        step();
        chk("st_memwb", bus.memwb, wb(32'h0, 32'h104, 5'd3, 1'b0, 1'b0, 1'b1, 32'h0062A223));
        step();
        bus.dm_ack = 1'b0;
        chk("held_memwb", bus.memwb, wb(32'h0, 32'h55, 5'd9, 1'b1, 1'b0, 1'b1, 32'h05500493));
        chk("held_stall", bus.stall, 0);

        // Branch that is also a load: redirect at acceptance.
        bus.exmem = ex(32'h20002303, 32'h200, 32'h0, 32'h00400100, 5'd6, C_V | C_MR | C_BR | C_Z);
        step();
        chk("brld_pc_src", bus.pc_src, 1);
        chk("brld_target", bus.branch_target, 32'h00400100);
        bus.exmem = '0;
        bus.dm_ack = 1'b1;
        bus.dm_rdata = 32'h0BADF00D;
        step();
        bus.dm_ack = 1'b0;
        chk("brld_pc_src_done", bus.pc_src, 0);
        chk("brld_memwb", bus.memwb, wb(32'h0BADF00D, 32'h200, 5'd6, 1'b0, 1'b0, 1'b1, 32'h20002303));

        // Misaligned load.
        bus.exmem = ex(32'h10202203, 32'h102, 32'h0, 32'h0, 5'd4, C_V | C_RW | C_MR);
        step();
        chk("mis_memwb", bus.memwb, wb(32'h0, 32'h102, 5'd4, 1'b0, 1'b0, 1'b1, 32'h10202203));
        chk("mis_req", bus.dm_req, 0);
        chk("mis_err", bus.mem_err, 1);
        bus.exmem = '0;

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_mem_err", bus.mem_err, 0);

        // Ack on the last permitted busy cycle: normal completion.
        bus.exmem = ex(32'h30002283, 32'h300, 32'h0, 32'h0, 5'd5, C_V | C_RW | C_MTR | C_MR);
        step();
        bus.exmem = '0;
        for (int i = 0; i < 15; i++) step();
        chk("edge_stall", bus.stall, 1);
        bus.dm_ack = 1'b1;
        bus.dm_rdata = 32'h600DD00D;
        step();
        bus.dm_ack = 1'b0;
        chk("edge_memwb", bus.memwb, wb(32'h600DD00D, 32'h300, 5'd5, 1'b1, 1'b1, 1'b1, 32'h30002283));
        chk("edge_mem_err", bus.mem_err, 0);

        // Timeout: no ack at all.
        bus.exmem = ex(32'h30002303, 32'h300, 32'h0, 32'h0, 5'd6, C_V | C_RW | C_MTR | C_MR);
        step();
        bus.exmem = '0;
        cyc = bus.stall ? 1 : 0;
        for (int i = 0; i < 40 && bus.stall; i++) begin
            step();
            if (bus.stall) cyc++;
        end
        chk("to_busy_cycles", cyc, 16);
        chk("to_memwb", bus.memwb, wb(32'hDEADBEEF, 32'h300, 5'd6, 1'b0, 1'b1, 1'b1, 32'h30002303));
        chk("to_mem_err", bus.mem_err, 1);
        step();
        step();
        chk("to_mem_err_sticky", bus.mem_err, 1);

        // Reset in the middle of a busy load; a late ack must be ignored.
        bus.exmem = ex(32'h40002383, 32'h400, 32'h0, 32'h0, 5'd7, C_V | C_RW | C_MR);
        step();
        bus.exmem = '0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_req", bus.dm_req, 0);
        chk("mrst_stall", bus.stall, 0);
        chk("mrst_memwb", bus.memwb, 0);
        bus.dm_ack = 1'b1;
        bus.dm_rdata = 32'h77777777;
        step();
        bus.dm_ack = 1'b0;
        chk("late_ack_memwb", bus.memwb, 0);
        chk("late_ack_stall", bus.stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage. Consumes the 141-bit `exmem` bundle driven by the EX stage and performs data-memory loads and stores over a req/ack handshake.
- Resolves branches.
- Registers a 104-bit `memwb` bundle for writeback.
- Stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max cycles to wait for `dm_ack` before aborting an access
- ERR_DATA, 32'hDEADBEEF, load data returned on timeout

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  reset, synchronous, active-low
- exmem  in  141  EX/MEM bundle: [31:0] branch target; [36:32] dest reg; [68:37] store data; [100:69] ALU result; [101] zero flag; [102] memread; [103] memwrite; [104] branch; [105] regwrite; [106] memtoreg; [107] jump; [108] valid; [140:109] instruction
- memwb  out  104  MEM/WB bundle: [31:0] load data; [63:32] ALU result; [68:64] dest reg; [69] regwrite; [70] memtoreg; [71] valid; [103:72] instruction
- stall  out  1  upstream must hold `exmem` while high
- pc_src  out  1  one-cycle redirect strobe
- branch_target  out  32  redirect address, valid with `pc_src`
- dm_req  out  1  memory request
- dm_we  out  1  1 = store
- dm_addr  out  32  word address (byte address, [1:0] = 0)
- dm_wdata  out  32  store data
- dm_rdata  in  32  load data, valid with `dm_ack`
- dm_ack  in  1  access complete, single-cycle pulse
- mem_err  out  1  sticky error: timeout or misalignment

Behaviour:
- Reset (RST_N=0 at posedge):
  - all outputs 0, state IDLE, timeout counter 0, `mem_err` cleared
  - applies mid-access: `dm_req` drops next cycle, and the in-flight op is discarded with no `memwb` valid.
- States: IDLE, BUSY.
- IDLE, valid=0: `memwb` updates next edge with valid=0 and regwrite=0 (bubble).
- IDLE, valid=1, memread=0 and memwrite=0:
  - `memwb` registered in 1 cycle: ALU result, dest reg, regwrite, memtoreg, instruction, valid=1; load data = 0.
- IDLE, valid=1, memread or memwrite:
  - If ALU result[1:0] != 0: no request; `mem_err` set; `memwb` valid=1 with regwrite=0.
  - Otherwise: capture the bundle into the hold register; drive `dm_req`=1, `dm_we`=memwrite, `dm_addr`=ALU result, `dm_wdata`=store data from the next cycle; move to BUSY; `memwb` valid=0 this cycle.
  - memread and memwrite both set: treated as a store.
- `stall` = (state == BUSY), combinational from the state register.
  - `exmem` is ignored while BUSY.
  - After return to IDLE, the held `exmem` is processed on the next edge.
- BUSY, `dm_ack`=1:
  - `dm_req` drops next cycle; state → IDLE.
  - `memwb` is loaded from the hold register, load data = `dm_rdata` for loads and 0 for stores.
  - Store forces regwrite=0.
- BUSY, no ack: counter increments each cycle.
  - At count == TIMEOUT-1 with no ack: abort as if acked; load data = ERR_DATA; regwrite=0; `mem_err`=1; counter cleared.
  - Ack on the same cycle as timeout: ack wins, no error.
- `dm_ack` while IDLE: ignored.
- Branch/jump:
  - `pc_src` registered: 1 for exactly one cycle after an IDLE-accepted valid op with (branch & zero) | jump; `branch_target` = exmem[31:0] on the same cycle.
  - Not produced for bubbles.
  - For a branch that is also a memory op: produced at acceptance, not at completion.
- `mem_err` clears only on reset.

Decomposition:
- Shared package `cpu_defs`:
  - EXMEM/MEMWB field offset and width constants
  - control-bit indices (MEMREAD=102 … VALID=108)
  - state encoding
- One sub-module, `dm_handshake`: the IDLE/BUSY FSM plus the timeout counter.
  - Outputs: req/we, done strobe, timeout strobe.
- `mem_stage` keeps the hold register, the bundle muxing and the branch logic.

Test Plan:
- ALU op `add` with ALU=0x00000010, dest=5, regwrite=1 → next cycle memwb[63:32]=0x10, [68:64]=5, [69]=1, [71]=1; stall stays 0.
- Load at 0x100, dm_ack after 3 cycles with rdata=0xCAFEF00D → stall high for 4 cycles; dm_addr=0x100, dm_we=0; memwb[31:0]=0xCAFEF00D on the cycle after ack.
- Store at 0x104 with data 0x12345678, back-to-back ALU op held upstream → dm_we=1, dm_wdata=0x12345678; memwb regwrite=0; held op appears in memwb one cycle after the store's memwb.
- Load with no ack, TIMEOUT=16 → abort after 16 BUSY cycles; memwb[31:0]=0xDEADBEEF, regwrite=0; mem_err=1 until reset.
- Branch with zero=1, target 0x00400020 → pc_src=1 for one cycle, branch_target=0x00400020. Same op with zero=0 → pc_src stays 0.
- RST_N low for one edge in the middle of a BUSY load → dm_req=0, stall=0 and memwb=0 next cycle; a late dm_ack is ignored.
